// File: rtl/subpixel_interp_hybrid_if.sv
// Bus between the luma interpolator, the reference-tile fetch memory and the MC datapath.
// master = interpolator side, slave = fetch memory / consumer side.
interface subpixel_interp_hybrid_if;
  logic [119:0]  in_row;
  logic [63:0]   next_row;
  logic [2559:0] out_A;
  logic [2559:0] out_B;
  logic [2559:0] out_C;
  logic [63:0]   fir_out_a;
  logic [63:0]   fir_out_b;
  logic [63:0]   fir_out_c;
  logic [959:0]  temp_B;
  logic [7:0]    cnt;
  logic [7:0]    sel;
  logic          load_out;
  logic [119:0]  currentPixels;

  modport master (
    input  in_row,
    output next_row, out_A, out_B, out_C, fir_out_a, fir_out_b, fir_out_c,
    output temp_B, cnt, sel, load_out, currentPixels
  );

  modport slave (
    output in_row,
    input  next_row, out_A, out_B, out_C, fir_out_a, fir_out_b, fir_out_c,
    input  temp_B, cnt, sel, load_out, currentPixels
  );
endinterface

// File: rtl/subpixel_interp_hybrid.sv
// HEVC luma quarter/half-sample interpolator for one 15x15 tile: 15 horizontal passes over the
// fetched rows, then 8 vertical passes over the integer columns 3..10 of the buffered tile.
module subpixel_interp_hybrid (
  input logic                    clk,
  input logic                    rst,
  subpixel_interp_hybrid_if.master bus
);

  typedef enum logic [1:0] {StHoriz = 2'd0, StVert = 2'd1, StDone = 2'd2} phase_e;

  phase_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [119:0]  rowbuf_q [15];
  logic [119:0]  cur_q;
  logic [2559:0] a_q, b_q, c_q;
  logic          load_q;

  logic          fetch_en;
  logic          wr_en;
  logic [5:0]    wr_idx;
  logic [63:0]   win [8];
  logic [63:0]   fir_a, fir_b, fir_c;

  // Signed 8-tap sum, round by 32, arithmetic shift by 6, clip to 8 bits.
  function automatic logic [7:0] fir8(input logic [63:0] px, input int kind);
    int acc;
    int c;
    acc = 0;
    for (int t = 0; t < 8; t++) begin
      case (kind)
        0: begin
          case (t)
            0: c = -1;  1: c = 4;  2: c = -10; 3: c = 58;
            4: c = 17;  5: c = -5; 6: c = 1;   default: c = 0;
          endcase
        end
        1: begin
          case (t)
            0: c = -1;  1: c = 4;   2: c = -11; 3: c = 40;
            4: c = 40;  5: c = -11; 6: c = 4;   default: c = -1;
          endcase
        end
        default: begin
          case (t)
            0: c = 0;   1: c = 1;   2: c = -5; 3: c = 17;
            4: c = 58;  5: c = -10; 6: c = 4;  default: c = -1;
          endcase
        end
      endcase
      acc = acc + c * int'(px[8*t +: 8]);
    end
    acc = (acc + 32) >>> 6;
    if (acc < 0) return 8'd0;
    if (acc > 255) return 8'd255;
    return acc[7:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fetch_en = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = '0;
    case (state_q)
      StHoriz: begin
        fetch_en = (cnt_q <= 8'd14);
        // Row fetched on the previous step is filtered now, one word behind the fetch.
        if (cnt_q != 8'd0) begin
          wr_en  = 1'b1;
          wr_idx = 6'(cnt_q - 8'd1);
        end
        if (cnt_q == 8'd15) begin
          state_d = StVert;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StVert: begin
        wr_en  = 1'b1;
        wr_idx = 6'(cnt_q + 8'd15);
        if (cnt_q == 8'd7) state_d = StDone;
        else               cnt_d   = cnt_q + 8'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int j = 0; j < 8; j++) begin
      for (int t = 0; t < 8; t++) begin
        if (state_q == StHoriz) begin
          win[j][8*t +: 8] = cur_q[8*(j+t) +: 8];
        end else begin
          win[j][8*t +: 8] = rowbuf_q[{1'b0, cnt_q[2:0]} + 4'(t)][8*(j+3) +: 8];
        end
      end
    end
    for (int j = 0; j < 8; j++) begin
      fir_a[8*j +: 8] = fir8(win[j], 0);
      fir_b[8*j +: 8] = fir8(win[j], 1);
      fir_c[8*j +: 8] = fir8(win[j], 2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StHoriz;
      cnt_q   <= '0;
      cur_q   <= '0;
      load_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      for (int i = 0; i < 15; i++) rowbuf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fetch_en) begin
        cur_q                <= bus.in_row;
        rowbuf_q[cnt_q[3:0]] <= bus.in_row;
      end
      if (wr_en) begin
        a_q[64*wr_idx +: 64] <= fir_a;
        b_q[64*wr_idx +: 64] <= fir_b;
        c_q[64*wr_idx +: 64] <= fir_c;
      end
      if (state_q == StVert && cnt_q == 8'd7) load_q <= 1'b1;
    end
  end

  assign bus.next_row      = (state_q == StHoriz && cnt_q <= 8'd14) ? {56'd0, cnt_q} : 64'd14;
  assign bus.out_A         = a_q;
  assign bus.out_B         = b_q;
  assign bus.out_C         = c_q;
  assign bus.fir_out_a     = fir_a;
  assign bus.fir_out_b     = fir_b;
  assign bus.fir_out_c     = fir_c;
  assign bus.temp_B        = b_q[959:0];
  assign bus.cnt           = cnt_q;
  assign bus.sel           = {6'd0, state_q};
  assign bus.load_out      = load_q;
  assign bus.currentPixels = cur_q;

endmodule

// File: tb/tb_subpixel_interp_hybrid.sv
// Bench for subpixel_interp_hybrid: directed tiles from the block's test list plus random tiles,
// all checked against a plain-arithmetic model of the three 8-tap luma filters.
module tb_subpixel_interp_hybrid;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  subpixel_interp_hybrid_if bus ();

  subpixel_interp_hybrid dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] tile [15][15];
  int tests = 0;
  int fails = 0;
  int fetch_r;

  // Combinational fetch memory.
  always_comb begin
    fetch_r = (bus.next_row < 64'd15) ? int'(bus.next_row[3:0]) : 0;
    for (int c = 0; c < 15; c++) bus.in_row[8*c +: 8] = tile[fetch_r][c];
  end

  localparam int Coef [3][8] = '{'{-1, 4, -10, 58, 17, -5, 1, 0},
                                 '{-1, 4, -11, 40, 40, -11, 4, -1},
                                 '{0, 1, -5, 17, 58, -10, 4, -1}};

  function automatic logic [7:0] ref_filter(int f, int px [8]);
    int s;
    s = 0;
    for (int t = 0; t < 8; t++) s += Coef[f][t] * px[t];
    s = (s + 32) >>> 6;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return 8'(s);
  endfunction

  // Expected banks packed as {A, B, C}.
  function automatic logic [7679:0] ref_banks();
    logic [63:0]   bank [3][40];
    int            px [8];
    logic [7679:0] r;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 40; k++) bank[f][k] = '0;
      for (int row = 0; row < 15; row++)
        for (int j = 0; j < 8; j++) begin
          for (int t = 0; t < 8; t++) px[t] = int'(tile[row][j+t]);
          bank[f][row][8*j +: 8] = ref_filter(f, px);
        end
      for (int k = 0; k < 8; k++)
        for (int j = 0; j < 8; j++) begin
          for (int t = 0; t < 8; t++) px[t] = int'(tile[k+t][j+3]);
          bank[f][15+k][8*j +: 8] = ref_filter(f, px);
        end
    end
    for (int k = 0; k < 40; k++) begin
      r[64*(80+k) +: 64] = bank[0][k];
      r[64*(40+k) +: 64] = bank[1][k];
      r[64*k +: 64]      = bank[2][k];
    end
    return r;
  endfunction

  function automatic int first_bad(logic [7679:0] g, logic [7679:0] e);
    for (int w = 0; w < 120; w++) if (g[64*w +: 64] !== e[64*w +: 64]) return w;
    return 0;
  endfunction

  task automatic fill(input logic [7:0] v);
    for (int r = 0; r < 15; r++) for (int c = 0; c < 15; c++) tile[r][c] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7679:0] got;
    for (int r = 0; r < 15; r++) for (int c = 0; c < 15; c++) tile[r][c] = 8'($urandom);
    do_reset();
    got = {bus.out_A, bus.out_B, bus.out_C};
    tests++;
    if (bus.cnt !== 8'd0 || bus.sel !== 8'd0) begin
      fails++;
      $display("FAIL reset_cnt_sel: got cnt=%0d sel=%0d, want 0 0", bus.cnt, bus.sel);
    end
    tests++;
    if (bus.load_out !== 1'b0 || bus.next_row !== 64'd0) begin
      fails++;
      $display("FAIL reset_load_row: got load=%b row=%0d, want 0 0", bus.load_out, bus.next_row);
    end
    tests++;
    if (bus.currentPixels !== 120'd0) begin
      fails++;
      $display("FAIL reset_pixels: got %h, want 0", bus.currentPixels);
    end
    tests++;
    if (got !== '0 || bus.temp_B !== '0) begin
      fails++;
      $display("FAIL reset_banks: word %0d got %h, want 0", first_bad(got, '0),
               got[64*first_bad(got, '0) +: 64]);
    end
  endtask

  task automatic test_flat();
    logic [7679:0] got, exp;
    fill(8'h80);
    do_reset();
    rst = 1'b0;
    repeat (23) @(posedge clk);
    #1;
    tests++;
    if (bus.load_out !== 1'b0) begin
      fails++;
      $display("FAIL flat_load_early: got %b after 23 edges, want 0", bus.load_out);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.load_out !== 1'b1 || bus.sel !== 8'd2) begin
      fails++;
      $display("FAIL flat_load: got load=%b sel=%0d after 24 edges, want 1 2",
               bus.load_out, bus.sel);
    end
    tests++;
    if (bus.out_A[64*22 +: 64] !== 64'h8080808080808080 || bus.out_C[64*23 +: 64] !== 64'd0) begin
      fails++;
      $display("FAIL flat_words: got A22=%h C23=%h, want 8080808080808080 0",
               bus.out_A[64*22 +: 64], bus.out_C[64*23 +: 64]);
    end
    exp = ref_banks();
    got = {bus.out_A, bus.out_B, bus.out_C};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL flat_banks: word %0d got %h want %h", first_bad(got, exp),
               got[64*first_bad(got, exp) +: 64], exp[64*first_bad(got, exp) +: 64]);
    end
  endtask

  task automatic test_impulse(input int r, input int c, input int word, input string name);
    logic [7679:0] got, exp;
    fill(8'h00);
    tile[r][c] = 8'h40;
    do_reset();
    rst = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    tests++;
    if (bus.out_A[64*word +: 8] !== 8'h3a || bus.out_B[64*word +: 8] !== 8'h28
        || bus.out_C[64*word +: 8] !== 8'h11) begin
      fails++;
      $display("FAIL %s_byte0: got A=%h B=%h C=%h, want 3a 28 11", name,
               bus.out_A[64*word +: 8], bus.out_B[64*word +: 8], bus.out_C[64*word +: 8]);
    end
    exp = ref_banks();
    got = {bus.out_A, bus.out_B, bus.out_C};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s_banks: word %0d got %h want %h", name, first_bad(got, exp),
               got[64*first_bad(got, exp) +: 64], exp[64*first_bad(got, exp) +: 64]);
    end
  endtask

  task automatic test_clip();
    fill(8'h00);
    tile[0][2] = 8'hFF;
    do_reset();
    rst = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    tests++;
    if (bus.out_A[7:0] !== 8'h00) begin
      fails++;
      $display("FAIL clip_neg: got A0 byte0=%h, want 00", bus.out_A[7:0]);
    end
    fill(8'h00);
    tile[0][1] = 8'hFF;
    tile[0][3] = 8'hFF;
    tile[0][4] = 8'hFF;
    tile[0][6] = 8'hFF;
    do_reset();
    rst = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    tests++;
    if (bus.out_B[7:0] !== 8'hFF || bus.temp_B[7:0] !== 8'hFF) begin
      fails++;
      $display("FAIL clip_pos: got B0 byte0=%h temp_B=%h, want ff ff",
               bus.out_B[7:0], bus.temp_B[7:0]);
    end
  endtask

  // Random tiles, following the step sequence and live filter outputs edge by edge.
  task automatic test_random();
    logic [7679:0] got, exp;
    logic [7:0]    want_cnt, want_sel;
    logic [63:0]   want_fir;
    int            nbad;
    for (int it = 0; it < 3; it++) begin
      for (int r = 0; r < 15; r++) for (int c = 0; c < 15; c++) tile[r][c] = 8'($urandom);
      exp = ref_banks();
      do_reset();
      rst  = 1'b0;
      nbad = 0;
      for (int s = 0; s < 24; s++) begin
        want_sel = (s < 16) ? 8'd0 : 8'd1;
        want_cnt = (s < 16) ? 8'(s) : 8'(s - 16);
        tests++;
        if (bus.sel !== want_sel || bus.cnt !== want_cnt
            || bus.next_row !== ((s < 15) ? 64'(s) : 64'd14)) begin
          fails++;
          $display("FAIL rand_seq step %0d: got sel=%0d cnt=%0d row=%0d, want %0d %0d", s,
                   bus.sel, bus.cnt, bus.next_row, want_sel, want_cnt);
        end
        if (s >= 1) begin
          // B bank lives at {A,B,C} words 40..79; A bank at 80..119.
          want_fir = (s < 16) ? exp[64*(40 + s - 1) +: 64] : exp[64*(80 + s - 1) +: 64];
          tests++;
          if (((s < 16) ? bus.fir_out_b : bus.fir_out_a) !== want_fir) begin
            fails++;
            nbad++;
            $display("FAIL rand_fir step %0d: got %h want %h", s,
                     (s < 16) ? bus.fir_out_b : bus.fir_out_a, want_fir);
          end
        end
        @(posedge clk);
        #1;
      end
      got = {bus.out_A, bus.out_B, bus.out_C};
      tests++;
      if (got !== exp || bus.load_out !== 1'b1) begin
        fails++;
        $display("FAIL rand_banks: load=%b word %0d got %h want %h", bus.load_out,
                 first_bad(got, exp), got[64*first_bad(got, exp) +: 64],
                 exp[64*first_bad(got, exp) +: 64]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7679:0] got, exp;
    fill(8'h80);
    do_reset();
    rst = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    tests++;
    if (bus.cnt !== 8'd7 || bus.out_A[63:0] === 64'd0) begin
      fails++;
      $display("FAIL midrst_pre: got cnt=%0d A0=%h, want 7 nonzero", bus.cnt, bus.out_A[63:0]);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (bus.cnt !== 8'd0 || bus.sel !== 8'd0 || bus.out_A !== '0 || bus.currentPixels !== '0
        || bus.next_row !== 64'd0 || bus.load_out !== 1'b0) begin
      fails++;
      $display("FAIL midrst_clear: got cnt=%0d sel=%0d A0=%h row=%0d, want all 0",
               bus.cnt, bus.sel, bus.out_A[63:0], bus.next_row);
    end
    rst = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    exp = ref_banks();
    got = {bus.out_A, bus.out_B, bus.out_C};
    tests++;
    if (got !== exp || bus.load_out !== 1'b1) begin
      fails++;
      $display("FAIL midrst_rerun: load=%b word %0d got %h want %h", bus.load_out,
               first_bad(got, exp), got[64*first_bad(got, exp) +: 64],
               exp[64*first_bad(got, exp) +: 64]);
    end
  endtask

  task automatic test_hold();
    logic [7679:0] got, exp;
    exp = {bus.out_A, bus.out_B, bus.out_C};
    repeat (10) @(posedge clk);
    #1;
    got = {bus.out_A, bus.out_B, bus.out_C};
    tests++;
    if (got !== ref_banks() || bus.sel !== 8'd2 || bus.load_out !== 1'b1) begin
      fails++;
      $display("FAIL done_hold: sel=%0d load=%b word %0d changed to %h", bus.sel,
               bus.load_out, first_bad(got, exp), got[64*first_bad(got, exp) +: 64]);
    end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_impulse(0, 3, 0, "imp_h");
    test_impulse(3, 3, 15, "imp_v");
    test_impulse(3, 3, 3, "imp_v_row");
    test_clip();
    test_random();
    test_hold();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
